regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port among 4 writeback requesters: ALU, load unit, link/JAL and mult/div.
- Round-robin arbitration; one write accepted per cycle.
- Registers the winning address and data.
- Drives the 16 one-hot register write-enables through a 4-to-16 decoder.
- Sits between the writeback stage and the 16-entry register file.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/decoder4_16.sv | 13 +
 rtl/regfile_write_arbiter.sv | 79 +++++++
 tb/tb_regfile_write_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Requester indices follow the writeback port order of the pipeline.
package regfile_pkg;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;

  localparam logic [AW-1:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    REQ_ALU  = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_LINK = 2'd2,
    REQ_MDU  = 2'd3
  } req_idx_e;

  typedef struct packed {
    logic     found;
    req_idx_e idx;
  } pick_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus plus register-file write port.
// The master side is the writeback stage and the register file; the slave side is the arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               wr_valid;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [(1<<AW)-1:0] wr_en;
  logic [1:0]         last_grant;

  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, wr_valid, wr_addr, wr_data, wr_en, last_grant
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, wr_valid, wr_addr, wr_data, wr_en, last_grant
  );

endinterface

// File: rtl/decoder4_16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module decoder4_16 (
  input  logic [3:0]  w,
  input  logic        en,
  output logic [15:0] out
);

  always_comb begin
    out = '0;
    if (en) out[w] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among four
// writeback requesters, with a registered write stage and one-hot enable decode.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter bit ZERO_WRITABLE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  logic [1:0]    ptr;
  pick_t         pick;
  logic          xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          dec_en;

  // Scan from the lowest priority to the highest so the first valid
  // requester in round-robin order is the last one recorded.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] valid,
                                    input logic [1:0]      start);
    pick_t      p;
    logic [1:0] idx;
    p.found = 1'b0;
    p.idx   = REQ_ALU;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = start + 2'(i);
      if (valid[idx]) begin
        p.found = 1'b1;
        p.idx   = req_idx_e'(idx);
      end
    end
    return p;
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    pick          = rr_pick(bus.req_valid, ptr);
    bus.req_ready = '0;
    if (pick.found && !bus.hold && !rst) bus.req_ready[pick.idx] = 1'b1;
  end

  assign xfer     = |bus.req_ready;
  assign win_addr = bus.req_addr[int'(pick.idx)*AW +: AW];
  assign win_data = bus.req_data[int'(pick.idx)*DW +: DW];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= 2'd0;
      bus.last_grant <= 2'd3;
      bus.wr_valid   <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
    end else begin
      bus.wr_valid <= xfer;
      if (xfer) begin
        ptr            <= 2'(pick.idx) + 2'd1;
        bus.last_grant <= 2'(pick.idx);
        bus.wr_addr    <= win_addr;
        bus.wr_data    <= win_data;
      end
    end
  end

  // r0 writes still retire through the handshake; only the enable is suppressed.
  assign dec_en = bus.wr_valid & ((bus.wr_addr != REG_ZERO) | ZERO_WRITABLE);

  decoder4_16 u_decoder (
    .w   (bus.wr_addr),
    .en  (dec_en),
    .out (bus.wr_en)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: two instances, r0 hardwired and r0 writable.
module tb_regfile_write_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_write_arbiter_if bus0 ();
  regfile_write_arbiter_if bus1 ();

  regfile_write_arbiter #(.ZERO_WRITABLE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_write_arbiter #(.ZERO_WRITABLE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus0.req_valid = '0; bus0.req_addr = '0; bus0.req_data = '0; bus0.hold = 1'b0;
    bus1.req_valid = '0; bus1.req_addr = '0; bus1.req_data = '0; bus1.hold = 1'b0;
  endtask

  // Leaves time at posedge+1 with rst low and inputs idle.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus0.req_valid = 4'b1111;
    #1;
    if (bus0.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=%b", bus0.req_ready, 4'b0000); end
    total++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (bus0.wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b exp=0", bus0.wr_valid); end
    total++;
    if (bus0.wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", bus0.wr_addr); end
    total++;
    if (bus0.wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", bus0.wr_data); end
    total++;
    if (bus0.wr_en !== 16'h0000) begin bad++; $display("FAIL reset_wr_en got=%h exp=0000", bus0.wr_en); end
    total++;
    if (bus0.last_grant !== 2'd3) begin bad++; $display("FAIL reset_last_grant got=%0d exp=3", bus0.last_grant); end
    total++;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    bus0.req_valid = 4'b0010;
    bus0.req_addr  = {4'd0, 4'd0, 4'd5, 4'd0};
    bus0.req_data  = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    #1;
    if (bus0.req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=%b", bus0.req_ready, 4'b0010); end
    total++;
    @(posedge clk); #1;
    bus0.req_valid = 4'b0000;
    if (bus0.wr_valid !== 1'b1) begin bad++; $display("FAIL single_wr_valid got=%b exp=1", bus0.wr_valid); end
    total++;
    if (bus0.wr_addr !== 4'd5) begin bad++; $display("FAIL single_wr_addr got=%h exp=5", bus0.wr_addr); end
    total++;
    if (bus0.wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wr_data got=%h exp=deadbeef", bus0.wr_data); end
    total++;
    if (bus0.wr_en !== 16'h0020) begin bad++; $display("FAIL single_wr_en got=%h exp=0020", bus0.wr_en); end
    total++;
    if (bus0.last_grant !== 2'd1) begin bad++; $display("FAIL single_last_grant got=%0d exp=1", bus0.last_grant); end
    total++;
    @(posedge clk); #1;
    if (bus0.wr_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", bus0.wr_valid); end
    total++;
    if (bus0.wr_addr !== 4'd5) begin bad++; $display("FAIL single_idle_addr_hold got=%h exp=5", bus0.wr_addr); end
    total++;
    if (bus0.wr_en !== 16'h0000) begin bad++; $display("FAIL single_idle_wr_en got=%h exp=0000", bus0.wr_en); end
    total++;
  endtask

  task automatic test_all_valid();
    logic [3:0]  exp_ready;
    logic [15:0] exp_en;
    int g;
    do_reset();
    bus0.req_valid = 4'b1111;
    bus0.req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    bus0.req_data  = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    #1;
    for (int k = 0; k < 8; k++) begin
      g = k % 4;
      exp_ready = 4'b0001 << g;
      exp_en    = 16'h0002 << g;
      if (bus0.req_ready !== exp_ready) begin bad++; $display("FAIL all_ready[%0d] got=%b exp=%b", k, bus0.req_ready, exp_ready); end
      total++;
      @(posedge clk); #1;
      if (bus0.wr_valid !== 1'b1 || bus0.wr_en !== exp_en || bus0.wr_data !== 32'h100 + 32'(g)
          || bus0.last_grant !== 2'(g)) begin
        bad++;
        $display("FAIL all_write[%0d] got v=%b en=%h d=%h lg=%0d exp v=1 en=%h d=%h lg=%0d",
                 k, bus0.wr_valid, bus0.wr_en, bus0.wr_data, bus0.last_grant, exp_en, 32'h100 + 32'(g), g);
      end
      total++;
      #1;
    end
    bus0.req_valid = 4'b0000;
  endtask

  task automatic test_r0();
    do_reset();
    bus0.req_valid = 4'b0100; bus0.req_addr = '0; bus0.req_data = {32'h0, 32'h1, 32'h0, 32'h0};
    bus1.req_valid = 4'b0100; bus1.req_addr = '0; bus1.req_data = {32'h0, 32'h1, 32'h0, 32'h0};
    #1;
    if (bus0.req_ready !== 4'b0100) begin bad++; $display("FAIL r0_ready got=%b exp=%b", bus0.req_ready, 4'b0100); end
    total++;
    @(posedge clk); #1;
    bus0.req_valid = 4'b0000;
    bus1.req_valid = 4'b0000;
    if (bus0.wr_valid !== 1'b1 || bus0.wr_data !== 32'h1) begin bad++; $display("FAIL r0_write got v=%b d=%h exp v=1 d=1", bus0.wr_valid, bus0.wr_data); end
    total++;
    if (bus0.wr_en !== 16'h0000) begin bad++; $display("FAIL r0_wr_en got=%h exp=0000", bus0.wr_en); end
    total++;
    if (bus1.wr_en !== 16'h0001) begin bad++; $display("FAIL r0_writable_wr_en got=%h exp=0001", bus1.wr_en); end
    total++;
  endtask

  task automatic test_hold();
    do_reset();
    bus0.req_valid = 4'b1111;
    bus0.req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    bus0.req_data  = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    #1;
    if (bus0.req_ready !== 4'b0001) begin bad++; $display("FAIL hold_pre_ready got=%b exp=%b", bus0.req_ready, 4'b0001); end
    total++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus0.hold = 1'b1;
      #1;
      if (bus0.req_ready !== 4'b0000) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=0000", k, bus0.req_ready); end
      total++;
      if (bus0.wr_valid !== (k == 0)) begin bad++; $display("FAIL hold_wr_valid[%0d] got=%b exp=%b", k, bus0.wr_valid, k == 0); end
      total++;
      if (bus0.last_grant !== 2'd0) begin bad++; $display("FAIL hold_last_grant[%0d] got=%0d exp=0", k, bus0.last_grant); end
      total++;
    end
    @(posedge clk); #1;
    bus0.hold = 1'b0;
    #1;
    if (bus0.wr_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b exp=0", bus0.wr_valid); end
    total++;
    if (bus0.req_ready !== 4'b0010) begin bad++; $display("FAIL hold_resume_ready got=%b exp=%b", bus0.req_ready, 4'b0010); end
    total++;
    @(posedge clk); #1;
    bus0.req_valid = 4'b0000;
    if (bus0.wr_valid !== 1'b1 || bus0.wr_addr !== 4'd2 || bus0.last_grant !== 2'd1) begin
      bad++;
      $display("FAIL hold_resume_write got v=%b a=%h lg=%0d exp v=1 a=2 lg=1", bus0.wr_valid, bus0.wr_addr, bus0.last_grant);
    end
    total++;
  endtask

  task automatic test_same_addr();
    do_reset();
    // Grant requester 2 alone to move the pointer to 3.
    bus0.req_valid = 4'b0100;
    bus0.req_addr  = {4'd7, 4'd9, 4'd0, 4'd7};
    bus0.req_data  = {32'hBBBB_0003, 32'h0000_0009, 32'h0, 32'hAAAA_0000};
    @(posedge clk); #1;
    bus0.req_valid = 4'b1001;
    #1;
    if (bus0.req_ready !== 4'b1000) begin bad++; $display("FAIL same_first_ready got=%b exp=%b", bus0.req_ready, 4'b1000); end
    total++;
    @(posedge clk); #1;
    bus0.req_valid = 4'b0001;
    if (bus0.wr_en !== 16'h0080 || bus0.wr_data !== 32'hBBBB_0003 || bus0.last_grant !== 2'd3) begin
      bad++;
      $display("FAIL same_first_write got en=%h d=%h lg=%0d exp en=0080 d=bbbb0003 lg=3", bus0.wr_en, bus0.wr_data, bus0.last_grant);
    end
    total++;
    #1;
    if (bus0.req_ready !== 4'b0001) begin bad++; $display("FAIL same_second_ready got=%b exp=%b", bus0.req_ready, 4'b0001); end
    total++;
    @(posedge clk); #1;
    bus0.req_valid = 4'b0000;
    if (bus0.wr_en !== 16'h0080 || bus0.wr_data !== 32'hAAAA_0000 || bus0.last_grant !== 2'd0) begin
      bad++;
      $display("FAIL same_second_write got en=%h d=%h lg=%0d exp en=0080 d=aaaa0000 lg=0", bus0.wr_en, bus0.wr_data, bus0.last_grant);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus0.req_valid = 4'b1111;
    bus0.req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    bus0.req_data  = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    @(posedge clk); #1;
    // Requester 0 accepted last cycle; reset together with hold now.
    rst = 1'b1;
    bus0.hold = 1'b1;
    #1;
    if (bus0.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", bus0.req_ready); end
    total++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.hold = 1'b0;
    if (bus0.wr_valid !== 1'b0 || bus0.wr_en !== 16'h0000 || bus0.last_grant !== 2'd3) begin
      bad++;
      $display("FAIL mid_rst_out got v=%b en=%h lg=%0d exp v=0 en=0000 lg=3", bus0.wr_valid, bus0.wr_en, bus0.last_grant);
    end
    total++;
    #1;
    if (bus0.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_rst_regrant got=%b exp=%b", bus0.req_ready, 4'b0001); end
    total++;
    @(posedge clk); #1;
    bus0.req_valid = 4'b0000;
    if (bus0.wr_addr !== 4'd1 || bus0.last_grant !== 2'd0) begin
      bad++;
      $display("FAIL mid_rst_write got a=%h lg=%0d exp a=1 lg=0", bus0.wr_addr, bus0.last_grant);
    end
    total++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_single();
    test_all_valid();
    test_r0();
    test_hold();
    test_same_addr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
